// File: rtl/cmp_fwd_if.sv
// ---------------------------------------------------------------------------
// cmp_fwd_if
// Purpose : Bundles the decode-side request, the in-flight result bus and the
//           forwarding/stall response of the compare forwarding unit.
// Signals : id_valid, id_rs, id_rf, id_wen, id_dst, id_tnew, flush, stg_data
//           (driven by the pipeline, master side); cmp_op, fwd_sel, stall,
//           stall_cnt (driven by the forwarding unit, slave side).
// ---------------------------------------------------------------------------
interface cmp_fwd_if #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NOPS  = 2,
    parameter int DEPTH = 3
) ();
    logic                  id_valid;
    logic [NOPS*AW-1:0]    id_rs;
    logic [NOPS*DW-1:0]    id_rf;
    logic                  id_wen;
    logic [AW-1:0]         id_dst;
    logic [1:0]            id_tnew;
    logic                  flush;
    logic [DEPTH*DW-1:0]   stg_data;
    logic [NOPS*DW-1:0]    cmp_op;
    logic [NOPS*2-1:0]     fwd_sel;
    logic                  stall;
    logic [15:0]           stall_cnt;

    modport master (
        output id_valid, id_rs, id_rf, id_wen, id_dst, id_tnew, flush, stg_data,
        input  cmp_op, fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rf, id_wen, id_dst, id_tnew, flush, stg_data,
        output cmp_op, fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/cmp_fwd_unit.sv
// ---------------------------------------------------------------------------
// cmp_fwd_unit
// Purpose : Decode-stage operand forwarding for compare/branch operands.
//           Tracks DEPTH in-flight writers (0=E, 1=M, 2=W) and, per operand,
//           forwards the youngest matching ready result or requests a stall
//           when the youngest matching writer has not produced its result.
// Ports   : clk   - clock, rising edge
//           reset - asynchronous, active-high
//           bus   - cmp_fwd_if slave: decode request, stage results in;
//                   cmp_op / fwd_sel / stall / stall_cnt out
// ---------------------------------------------------------------------------
module cmp_fwd_unit #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NOPS  = 2,
    parameter int DEPTH = 3
) (
    input  logic     clk,
    input  logic     reset,
    cmp_fwd_if.slave bus
);

    // In-flight table, index 0 is the youngest entry (E stage)
    logic              r_valid [DEPTH];
    logic [AW-1:0]     r_dst   [DEPTH];
    logic [1:0]        r_tnew  [DEPTH];
    logic [15:0]       r_stall_cnt;

    logic [NOPS-1:0]   w_op_stall;
    logic [NOPS*DW-1:0] w_cmp_op;
    logic [NOPS*2-1:0] w_fwd_sel;
    logic              w_stall;
    logic              w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NOPS; gi++) begin : g_op
            logic [AW-1:0] w_rs;
            logic          w_hit;
            logic [1:0]    w_hit_tnew;
            logic [1:0]    w_hit_sel;
            logic [DW-1:0] w_hit_data;
            logic          w_fwd;

            assign w_rs = bus.id_rs[gi*AW +: AW];

            always_comb begin
                w_hit      = 1'b0;
                w_hit_tnew = 2'd0;
                w_hit_sel  = 2'd0;
                w_hit_data = '0;
                // Walk oldest to youngest so the youngest match wins; an older
                // ready copy must never mask a younger not-ready writer.
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (r_valid[i] && (r_dst[i] == w_rs)) begin
                        w_hit      = 1'b1;
                        w_hit_tnew = r_tnew[i];
                        w_hit_sel  = 2'(i + 1);
                        w_hit_data = bus.stg_data[i*DW +: DW];
                    end
                end
                // Register 0 is hard-wired, never forwarded
                if (w_rs == '0) begin
                    w_hit = 1'b0;
                end
            end

            // Not-ready youngest match falls back to id_rf (value is don't-care
            // because decode is held), never to an older entry.
            assign w_fwd          = !reset && w_hit && (w_hit_tnew == 2'd0);
            assign w_op_stall[gi] = w_hit && (w_hit_tnew != 2'd0);
            assign w_cmp_op[gi*DW +: DW] = w_fwd ? w_hit_data : bus.id_rf[gi*DW +: DW];
            assign w_fwd_sel[gi*2 +: 2]  = w_fwd ? w_hit_sel : 2'd0;
        end
    endgenerate

    // Flush dominates: the killed instruction neither stalls nor enters E
    assign w_stall  = !reset && bus.id_valid && !bus.flush && (|w_op_stall);
    assign w_accept = bus.id_valid && !bus.flush && !w_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_dst[i]   <= '0;
                r_tnew[i]  <= 2'd0;
            end
        end else begin
            // Writers to register 0 are recorded as bubbles
            r_valid[0] <= w_accept && bus.id_wen && (bus.id_dst != '0);
            r_dst[0]   <= w_accept ? bus.id_dst : '0;
            r_tnew[0]  <= w_accept ? bus.id_tnew : 2'd0;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_dst[i]   <= r_dst[i-1];
                r_tnew[i]  <= (r_tnew[i-1] == 2'd0) ? 2'd0 : (r_tnew[i-1] - 2'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.cmp_op    = w_cmp_op;
    assign bus.fwd_sel   = w_fwd_sel;
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: doc/cmp_fwd_unit.md
CMP_FWD_UNIT -- requirements
Module: cmp_fwd_unit

Interface
REQ-001 SHALL provide parameter DW, default 32, data width of operands and forwarded results.
REQ-002 SHALL provide parameter AW, default 5, register-address width.
REQ-003 SHALL provide parameter NOPS, default 2, number of decode-stage compare operands served.
REQ-004 SHALL provide parameter DEPTH, default 3, number of tracked in-flight stages (index 0=E, 1=M, 2=W).
REQ-005 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port id_valid  in  1  valid instruction in decode.
REQ-008 SHALL have port id_rs  in  NOPS*AW  source register per operand (operand k at bits k*AW+:AW).
REQ-009 SHALL have port id_rf  in  NOPS*DW  register-file read value per operand.
REQ-010 SHALL have port id_wen, id_dst, id_tnew  in  1 / AW / 2  decode instruction writes id_dst; result ready id_tnew cycles after entering E.
REQ-011 SHALL have port flush  in  1  kill the decode instruction (bubble inserted instead).
REQ-012 SHALL have port stg_data  in  DEPTH*DW  result currently available at stage i (bits i*DW+:DW).
REQ-013 SHALL have port cmp_op  out  NOPS*DW  forwarded operand per operand.
REQ-014 SHALL have port fwd_sel  out  NOPS*2  per operand: 0 = id_rf, 1+i = stg_data stage i (DEPTH<=3 for this encoding).
REQ-015 SHALL have port stall  out  1  decode must hold.
REQ-016 SHALL have port stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-017 SHALL hold a DEPTH-entry in-flight table, each entry {valid, dst, tnew}.
REQ-018 SHALL advance the table every cycle: entry i -> i+1, entry DEPTH-1 discarded, tnew decremented with saturation at 0.
REQ-019 SHALL load entry 0 with {id_wen & (id_dst!=0), id_dst, id_tnew} when id_valid & !stall & !flush; otherwise entry 0 SHALL become invalid (bubble).
REQ-020 SHALL, per operand, search entries 0..DEPTH-1 for valid & dst==rs, selecting the lowest index (youngest) match only.
REQ-021 SHALL, on a match with tnew==0, drive cmp_op = stg_data[i] and fwd_sel = 1+i combinationally (zero-cycle latency).
REQ-022 SHALL, on no match or rs==0, drive cmp_op = id_rf and fwd_sel = 0.
REQ-023 SHALL assert stall when id_valid & !flush and any operand's youngest match has tnew!=0; an older ready match SHALL NOT suppress this stall.
REQ-024 SHALL, while stall is asserted, still drive cmp_op/fwd_sel per REQ-021/022 for the youngest match, ignoring the not-ready entry's data.
REQ-025 SHALL increment stall_cnt on each clock edge with stall=1, holding at 16'hFFFF.
REQ-026 SHALL give flush priority over id_valid: flush forces stall=0 and a bubble into entry 0 the same edge.
REQ-027 SHALL treat id_dst==0 writers as non-writers (never forwarded, never stall).

Reset
REQ-028 SHALL, on reset assertion, immediately invalidate all table entries, zero all tnew/dst fields and clear stall_cnt, without waiting for clk.
REQ-029 SHALL, while reset is high, output stall=0, fwd_sel=0, cmp_op=id_rf.
REQ-030 SHALL resume tracking on the first rising clk edge after reset deassertion; an instruction presented then is accepted normally.

Verification
REQ-031 SHALL be verified: issue wen dst=8 tnew=0; next cycle rs0=8, stg_data[0]=0x11 -> cmp_op0=0x11, fwd_sel0=1, stall=0.
REQ-032 SHALL be verified: load dst=9 tnew=2, next rs1=9 -> stall=1 for 2 cycles, then fwd_sel1=3 with stg_data[2]; stall_cnt=2.
REQ-033 SHALL be verified: dst=5 in M (ready, 0xAA) and dst=5 in E (ready, 0xBB), rs0=5 -> cmp_op0=0xBB, fwd_sel0=1.
REQ-034 SHALL be verified: writer dst=0 in E, rs0=0, id_rf=0 -> cmp_op0=0, fwd_sel0=0, stall=0.
REQ-035 SHALL be verified: flush concurrent with hazard -> stall=0; following cycle entry 0 invalid, no forward from it.
REQ-036 SHALL be verified: reset pulse mid-stall (between edges) -> stall=0, stall_cnt=0 immediately; 70000 forced stall cycles -> stall_cnt=16'hFFFF.
